// File: rtl/sha2_msg_schedule_if.sv
// Block-in / schedule-word-out handshake bundle for sha2_msg_schedule.
// slave is the schedule generator side, master is the producer/consumer side.
interface sha2_msg_schedule_if #(
  parameter int unsigned WORD_W = 32
);
  logic                    blk_valid;
  logic                    blk_ready;
  logic [16*WORD_W-1:0]    blk_data;
  logic                    w_valid;
  logic                    w_ready;
  logic [WORD_W-1:0]       w_data;
  logic [6:0]              w_idx;
  logic                    w_last;

  modport slave (
    input  blk_valid, blk_data, w_ready,
    output blk_ready, w_valid, w_data, w_idx, w_last
  );

  modport master (
    output blk_valid, blk_data, w_ready,
    input  blk_ready, w_valid, w_data, w_idx, w_last
  );
endinterface

// File: rtl/sha2_msg_schedule.sv
// SHA-2 message schedule: loads a 16-word block and streams W[0..ROUNDS-1].
// Define SHA2_SCHED_B2B_EN to accept the next block on the last output beat.
module sha2_msg_schedule #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ROUNDS = 64
) (
  input logic                clk,
  input logic                rst,
  input logic                clr,
  sha2_msg_schedule_if.slave bus
);

  if (!((WORD_W == 32 && ROUNDS == 64) || (WORD_W == 64 && ROUNDS == 80))) begin : g_bad_cfg
    $fatal(1, "sha2_msg_schedule: illegal WORD_W/ROUNDS pair");
  end

  localparam bit          Wide   = (WORD_W == 64);
  localparam int unsigned S0Ra   = Wide ? 1  : 7;
  localparam int unsigned S0Rb   = Wide ? 8  : 18;
  localparam int unsigned S0Sh   = Wide ? 7  : 3;
  localparam int unsigned S1Ra   = Wide ? 19 : 17;
  localparam int unsigned S1Rb   = Wide ? 61 : 19;
  localparam int unsigned S1Sh   = Wide ? 6  : 10;
  localparam logic [6:0]  LastIdx = 7'(ROUNDS - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, S0Ra) ^ rotr(x, S0Rb) ^ (x >> S0Sh);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, S1Ra) ^ rotr(x, S1Rb) ^ (x >> S1Sh);
  endfunction

  state_e            state_q, state_d;
  logic [6:0]        idx_q, idx_d;
  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] win_d [16];
  logic [WORD_W-1:0] w_new;
  logic              w_valid, w_last, blk_ready;
  logic              accept, beat;

  assign w_valid = (state_q == StRun);
  assign w_last  = w_valid && (idx_q == LastIdx);

`ifdef SHA2_SCHED_B2B_EN
  assign blk_ready = (state_q == StIdle) || (w_valid && w_last && bus.w_ready);
`else
  assign blk_ready = (state_q == StIdle);
`endif

  assign accept = bus.blk_valid && blk_ready;
  assign beat   = w_valid && bus.w_ready;
  assign w_new  = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

  assign bus.blk_ready = blk_ready;
  assign bus.w_valid   = w_valid;
  assign bus.w_data    = win_q[0];
  assign bus.w_idx     = idx_q;
  assign bus.w_last    = w_last;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
    // clr beats any accept or beat; an accept on the last beat wins over the return to idle
    if (clr) begin
      state_d = StIdle;
      idx_d   = '0;
    end else if (accept) begin
      state_d = StRun;
      idx_d   = '0;
      for (int i = 0; i < 16; i++) win_d[i] = bus.blk_data[(15-i)*WORD_W +: WORD_W];
    end else if (beat) begin
      idx_d = idx_q + 7'd1;
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15] = w_new;
      if (idx_q == LastIdx) state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

endmodule
